pc_flags_unit: RTL

- Program-counter and status-flag stage of the one-cycle processor.
- Consumes the decoded branch strobes and flags_write from the control decoder, plus ALU status bits.
- Holds the PC register and the architectural flag register, and resolves conditional and unconditional jumps.
- Drives the instruction-memory address; also tracks retired instructions and a sticky halt on jump-to-self.

---
 rtl/pc_flags_unit.sv | 88 ++++++++
 1 files changed

// File: rtl/pc_flags_unit.sv
// Program-counter and status-flag stage: holds PC and {V,C,N,Z} flags, resolves
// jumps against the registered flags, counts retired instructions, halts on jump-to-self.
module pc_flags_unit #(
  parameter int                     PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                     RET_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flags_write,
  input  logic                  is_jz,
  input  logic                  is_jnz,
  input  logic                  is_jg,
  input  logic                  is_jl,
  input  logic                  is_jump,
  input  logic [PC_WIDTH-1:0]   jump_target,
  input  logic                  alu_zero,
  input  logic                  alu_sign,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [3:0]            flags,
  output logic                  branch_taken,
  output logic                  halted,
  output logic [RET_WIDTH-1:0]  retired_count
);

  localparam logic [PC_WIDTH-1:0]  PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RET_WIDTH-1:0] RET_ONE = {{(RET_WIDTH-1){1'b0}}, 1'b1};

  logic flag_z;
  logic flag_n;
  logic flag_v;
  logic less;
  logic greater;
  logic cond_taken;
  logic advance;
  logic self_jump;

  // Conditions always come from the registered flags, so a same-cycle flag update
  // never affects the branch decision of its own instruction.
  always_comb begin
    flag_z     = flags[0];
    flag_n     = flags[1];
    flag_v     = flags[3];
    less       = flag_n ^ flag_v;
    greater    = ~flag_z & ~less;
    cond_taken = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z)
               | (is_jg & greater) | (is_jl & less);
    if (halted) begin
      branch_taken = 1'b0;
    end else begin
      branch_taken = cond_taken;
    end
    advance   = ~stall & ~halted;
    self_jump = branch_taken & (jump_target == pc);
  end

  // Architectural state update; reset dominates stall and halt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      flags         <= 4'b0000;
      halted        <= 1'b0;
      retired_count <= '0;
    end else if (advance) begin
      pc            <= branch_taken ? jump_target : pc + PC_ONE;
      retired_count <= retired_count + RET_ONE;
      if (flags_write) begin
        flags <= {alu_overflow, alu_carry, alu_sign, alu_zero};
      end else begin
        flags <= flags;
      end
      if (self_jump) begin
        halted <= 1'b1;
      end else begin
        halted <= halted;
      end
    end else begin
      pc            <= pc;
      flags         <= flags;
      halted        <= halted;
      retired_count <= retired_count;
    end
  end

endmodule
